obi_arb2: RTL
=============

Name: obi_arb2

Overview:
Two-master to one-slave OBI arbiter for the shared data/RAM port. Master 0 is the core data port; master 1 is the BootLoader or a future DMA. The block sequences address phases onto one slave, tracks outstanding transactions in order, and routes each response back to its owner. It sits between the requesters and the address decode / `bus_mux` slave side.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8)
OUTST_DEPTH, 2, maximum outstanding granted-but-unanswered transactions (power of 2, ≥1)
FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous active-high reset
m0_req / m1_req  in  1  master request
m0_gnt / m1_gnt  out  1  master grant
m0_addr / m1_addr  in  ADDR_W  address
m0_we / m1_we  in  1  write enable
m0_be / m1_be  in  DATA_W/8  byte enables
m0_wdata / m1_wdata  in  DATA_W  write data
m0_rvalid / m1_rvalid  out  1  response valid
m0_rdata / m1_rdata  out  DATA_W  read data
s_req  out  1  slave request
s_gnt  in  1  slave grant
s_addr  out  ADDR_W  muxed address
s_we  out  1  muxed write enable
s_be  out  DATA_W/8  muxed byte enables
s_wdata  out  DATA_W  muxed write data
s_rvalid  in  1  slave response valid
s_rdata  in  DATA_W  slave read data
outst_cnt  out  $clog2(OUTST_DEPTH+1)  outstanding count (debug)
rsp_err  out  1  sticky: rvalid received with nothing outstanding

Behaviour:
- One clock; reset is synchronous and active-high. Ports are Clk and Rst.
- Reset state:
  - all gnt, rvalid and s_req outputs 0; outst_cnt 0; rsp_err 0
  - owner FIFO empty; lock clear; last_grant = 1, so m0 wins first under round-robin
- Full condition: full = (outst_cnt == OUTST_DEPTH). s_req = (m0_req | m1_req) & !full.
- Winner selection (combinational):
  - If locked, winner = lock_id.
  - Else if only one master requests, that master wins.
  - Else if both request: FIXED_PRIO=1 → m0; else the master ≠ last_grant.
- Address-phase mux: s_addr, s_we, s_be and s_wdata come from the winner. When s_req=0 they are driven 0.
- Grant: mk_gnt = s_req & s_gnt & (winner==k). Zero-cycle combinational path; the loser's gnt is 0.
- Handshake: hs = s_req & s_gnt.
  - Push winner id into the owner FIFO; last_grant <= winner.
- Lock (OBI stability rule):
  - If s_req & !s_gnt, register lock=1, lock_id=winner.
  - Lock clears on hs.
  - A new requester never preempts a stalled address phase.
- Response:
  - Pop the FIFO head on s_rvalid.
  - mk_rvalid = s_rvalid & !empty & (head==k).
  - mk_rdata = s_rdata, broadcast to both; meaningful only with rvalid.
  - Responses are returned in grant order. The slave guarantees in-order responses, and rvalid is never earlier than the cycle after gnt.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, s_req is gated by the registered count only; there is no same-cycle bypass.
- s_rvalid while empty:
  - No pop, no master rvalid.
  - rsp_err <= 1, held until Rst.
- Request deasserted while locked:
  - Protocol violation by the master; the block is not required to recover.
  - The lock remains until hs or Rst.
- Reset mid-operation: FIFO and lock are flushed. Pending slave responses are assumed cleared by the same system reset.
- Counter wrap: FIFO read/write pointers are $clog2(OUTST_DEPTH) bits with natural wrap; count is tracked separately.

Decomposition:
- Package obi_arb_pkg:
  - typedef mid_t (1-bit master id)
  - constants M0_ID=0, M1_ID=1
  - localparam function for the count width
- Sub-module obi_id_fifo: a synchronous FIFO of mid_t, depth OUTST_DEPTH.
  - Ports: push, pop, din, head, empty, full, count.
  - Holds the owner-tracking storage.
- The top contains the arbitration, lock and mux logic.

Test Plan:
- After reset, m0_req=1, m1_req=1, s_gnt=1 in the same cycle → m0_gnt=1, m1_gnt=0. Next cycle (both still requesting) → m1_gnt=1, confirming round-robin alternation.
- m1_req with addr 0x1000_0040, s_gnt=0 for 3 cycles, m0_req rises in cycle 2 → s_addr stays 0x1000_0040. m1_gnt=1 when s_gnt=1 in cycle 4; m0 is granted afterwards.
- OUTST_DEPTH=2: two granted reads with no s_rvalid, then a third request → s_req=0 and outst_cnt=2. s_rvalid with s_rdata=0xDEADBEEF → m0_rvalid pulses with 0xDEADBEEF and s_req reasserts the next cycle.
- Interleaved grants m0, m1, m0, then three in-order s_rvalid carrying 0x11, 0x22, 0x33 → m0 receives 0x11, m1 receives 0x22, m0 receives 0x33.
- s_rvalid=1 with outst_cnt=0 → no master rvalid and rsp_err=1. rsp_err stays set until a Rst pulse clears it to 0.
- FIXED_PRIO=1, both masters requesting continuously, s_gnt=1 → m0_gnt=1 every cycle and m1 is never granted. Assert Rst mid-sequence → outst_cnt=0 and all gnt outputs 0 the cycle after.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the two-master OBI arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package obi_arb_pkg;

    // Master identifier carried through the owner FIFO
    typedef logic mid_t;

    localparam mid_t M0_ID = 1'b0;
    localparam mid_t M1_ID = 1'b1;

    // Width needed to hold a count of 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// Owner-tracking FIFO: records which master owns each outstanding transaction.
// Latency: push is visible at head the cycle after it is written; pop is immediate.
// Backpressure: none internally; the caller must not push when full or pop when empty.
// Ports: Clk/Rst (sync active-high), push/din write side, pop/head read side,
//        empty/full/count status.
module obi_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic             pop,
    input  mid_t             din,
    output mid_t             head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mid_t             mem_q [DEPTH];
    mid_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap keeps DEPTH=1 safe; identical to natural wrap for powers of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= M0_ID;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/obi_arb2.sv
// Two-master to one-slave OBI arbiter with in-order response routing.
// Latency: zero-cycle combinational request/grant path; responses routed combinationally.
// Backpressure: s_req drops while OUTST_DEPTH transactions are outstanding; a stalled
//               address phase is locked to its master until the slave grants it.
// Ports: Clk/Rst (sync active-high); m0_*/m1_* master OBI ports; s_* slave OBI port;
//        outst_cnt debug count; rsp_err sticky flag for a response with nothing outstanding.
module obi_arb2
    import obi_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTST_DEPTH = 2,
    parameter bit FIXED_PRIO  = 1'b0,
    localparam int BE_W  = DATA_W / 8,
    localparam int CNT_W = cnt_width(OUTST_DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              m0_req,
    output logic              m0_gnt,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    output logic              m1_gnt,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    input  logic              s_gnt,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_we,
    output logic [BE_W-1:0]   s_be,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [CNT_W-1:0]  outst_cnt,
    output logic              rsp_err
);

    logic lock_q, lock_d;
    mid_t lock_id_q, lock_id_d;
    mid_t last_grant_q, last_grant_d;
    logic rsp_err_q, rsp_err_d;

    mid_t winner;
    logic hs;
    logic pop;
    logic fifo_empty;
    logic fifo_full;
    mid_t fifo_head;

    // Outputs are held quiet while reset is asserted
    assign s_req = (m0_req | m1_req) & ~fifo_full & ~Rst;
    assign hs    = s_req & s_gnt;
    assign pop   = s_rvalid & ~fifo_empty & ~Rst;

    always_comb begin
        winner = M0_ID;
        if (lock_q) begin
            winner = lock_id_q;
        end else if (m0_req && !m1_req) begin
            winner = M0_ID;
        end else if (m1_req && !m0_req) begin
            winner = M1_ID;
        end else if (m0_req && m1_req) begin
            winner = FIXED_PRIO ? M0_ID : ((last_grant_q == M0_ID) ? M1_ID : M0_ID);
        end
    end

    always_comb begin
        s_addr  = '0;
        s_we    = 1'b0;
        s_be    = '0;
        s_wdata = '0;
        if (s_req) begin
            if (winner == M1_ID) begin
                s_addr  = m1_addr;
                s_we    = m1_we;
                s_be    = m1_be;
                s_wdata = m1_wdata;
            end else begin
                s_addr  = m0_addr;
                s_we    = m0_we;
                s_be    = m0_be;
                s_wdata = m0_wdata;
            end
        end
    end

    assign m0_gnt = hs & (winner == M0_ID);
    assign m1_gnt = hs & (winner == M1_ID);

    assign m0_rvalid = pop & (fifo_head == M0_ID);
    assign m1_rvalid = pop & (fifo_head == M1_ID);
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

    // A stalled address phase pins the winner so the slave sees a stable request
    always_comb begin
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        rsp_err_d    = rsp_err_q | (s_rvalid & fifo_empty);
        if (hs) begin
            lock_d       = 1'b0;
            last_grant_d = winner;
        end else if (s_req) begin
            lock_d    = 1'b1;
            lock_id_d = winner;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            lock_q       <= 1'b0;
            lock_id_q    <= M0_ID;
            last_grant_q <= M1_ID;
            rsp_err_q    <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;

    obi_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (hs),
        .pop   (pop),
        .din   (winner),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (outst_cnt)
    );

endmodule
